ibuff_queue: RTL and testbench
==============================

// Module: ibuff_queue
// PURPOSE
//  Instruction buffer between fetch and the D1 decode stage; producer side of D1's IBuff_in interface.
//  Accepts one fetched instruction per cycle with its PC and fetch-exception flag.
//  Stores entries in a DEPTH-entry circular FIFO and presents the oldest entry to D1 with a valid/ready handshake.
//  Flushes all entries on resteer, from the branch unit or the ROB.
// PARAMETERS
//  XLEN   32  instruction/PC width
//  DEPTH  8   entry count; power of 2, >= 2
//  NOP    32'h00000013  value driven on IBuff_out when no valid entry
// PORTS
//  clk              in   1                  clock, rising edge
//  rst              in   1                  asynchronous reset, active-high
//  fetch_valid      in   1                  fetch presents an entry
//  fetch_instr      in   XLEN               fetched instruction
//  fetch_pc         in   XLEN               PC of fetched instruction
//  fetch_exception  in   1                  fetch fault on this entry
//  fetch_ready      out  1                  buffer can accept (not full)
//  ibuff_valid      out  1                  head entry valid to D1
//  d1_ready         in   1                  D1 consumes head this cycle
//  IBuff_out        out  XLEN               head instruction (drives D1 IBuff_in)
//  pc_out           out  XLEN               head PC
//  exception_out    out  1                  head fetch-exception flag
//  resteer          in   1                  flush all entries
//  count            out  $clog2(DEPTH)+1    occupied entries
// BEHAVIOUR
//  - Reset (async): rd_ptr=wr_ptr=0, count=0, fetch_ready=1, ibuff_valid=0.
//    Also during reset: IBuff_out=NOP, pc_out=0, exception_out=0. Storage contents are don't-care.
//  - Push = fetch_valid & fetch_ready & ~resteer. Pop = ibuff_valid & d1_ready.
//  - fetch_ready = (count != DEPTH); it depends on count only.
//    When full, a push is refused even if a pop happens in the same cycle.
//  - Push writes {instr,pc,exc} at wr_ptr; wr_ptr increments mod DEPTH. Pop increments rd_ptr mod DEPTH.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally. count tracks occupancy: +1 push, -1 pop, unchanged on both.
//  - Latency push->ibuff_valid: 1 cycle. Outputs are a combinational read of the registered head entry.
//  - ibuff_valid = (count != 0) & ~resteer. When ibuff_valid=0: IBuff_out=NOP, pc_out=0, exception_out=0.
//  - Resteer has priority over push and pop in the same cycle.
//    Next edge: rd_ptr=wr_ptr=0, count=0. The fetch entry offered in the resteer cycle is dropped.
//  - Exception entries are queued and popped like any entry. D1 owns exception handling.
//  - Pop when empty: no-op, pointers hold. Push and pop together at count=1: count stays 1, head advances.
//  - Reset mid-operation: all entries lost; outputs take reset values immediately.
// CONFIGURATION
//  IBUFF_BYPASS_EN defined:
//    - When count==0 and fetch_valid & ~resteer, the fetch entry drives the outputs combinationally and ibuff_valid=1 in the same cycle.
//    - If d1_ready is also 1, the entry is consumed and not written; count stays 0.
//    - If d1_ready is 0, the entry is written normally.
//  IBUFF_BYPASS_EN undefined: no bypass; minimum push->valid latency is 1 cycle.
// TESTING
//  1. Reset, then push A (instr 0xA5A5A5A5, pc 0x100), d1_ready=0
//     -> next cycle ibuff_valid=1, IBuff_out=A5A5A5A5, pc_out=100, count=1.
//  2. Push 8 entries, d1_ready=0 -> fetch_ready=0, count=8.
//     A 9th push is ignored. Then pop 8 with d1_ready=1 -> entries emerge in order, wrap correct, count=0, IBuff_out=NOP.
//  3. Full, push and pop in the same cycle -> push refused, count=7.
//     At count=3 with push+pop together -> count stays 3.
//  4. count=5, resteer=1 with fetch_valid=1 -> in that cycle ibuff_valid=0.
//     Next cycle count=0 and the offered entry is absent. A following push appears 1 cycle later.
//  5. Push pc 0x200 with fetch_exception=1 -> head shows exception_out=1, pc_out=200. The next entry shows exception_out=0.
//  6. Assert rst at count=4 -> ibuff_valid=0 and fetch_ready=1 immediately, without waiting for a clk edge.
//     With IBUFF_BYPASS_EN: on an empty buffer, push plus d1_ready -> same-cycle valid and count stays 0.

Source files
------------

// File: rtl/ibuff_queue_if.sv
// ============================================================================
// Module  : ibuff_queue_if
// Brief   : Fetch-side and D1-side handshake bundle for the instruction buffer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface ibuff_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  localparam int C_CNT_W = $clog2(DEPTH) + 1;

  logic               fetch_valid;
  logic [XLEN-1:0]    fetch_instr;
  logic [XLEN-1:0]    fetch_pc;
  logic               fetch_exception;
  logic               fetch_ready;
  logic               ibuff_valid;
  logic               d1_ready;
  logic [XLEN-1:0]    IBuff_out;
  logic [XLEN-1:0]    pc_out;
  logic               exception_out;
  logic               resteer;
  logic [C_CNT_W-1:0] count;

  modport master (
    output fetch_valid, fetch_instr, fetch_pc, fetch_exception,
    output d1_ready, resteer,
    input  fetch_ready, ibuff_valid, IBuff_out, pc_out, exception_out, count
  );

  modport slave (
    input  fetch_valid, fetch_instr, fetch_pc, fetch_exception,
    input  d1_ready, resteer,
    output fetch_ready, ibuff_valid, IBuff_out, pc_out, exception_out, count
  );
endinterface

`default_nettype wire

// File: rtl/ibuff_queue.sv
// ============================================================================
// Module  : ibuff_queue
// Brief   : Circular instruction buffer between fetch and D1 decode.
//           Optional same-cycle bypass when empty: define IBUFF_BYPASS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ibuff_queue #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 8,
  parameter logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013)
) (
  input  wire logic     clk,
  input  wire logic     rst,
  ibuff_queue_if.slave  bus
);
  localparam int                 C_PTR_W     = $clog2(DEPTH);
  localparam int                 C_CNT_W     = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH_CNT = C_CNT_W'(DEPTH);

  logic [XLEN-1:0]    r_instr_mem [DEPTH];
  logic [XLEN-1:0]    r_pc_mem    [DEPTH];
  logic [DEPTH-1:0]   r_exc_mem;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_push_ok;
  logic w_bypass;
  logic w_valid;
  logic w_pop;
  logic w_write;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH_CNT);
  assign w_push_ok = bus.fetch_valid & ~w_full & ~bus.resteer;

`ifdef IBUFF_BYPASS_EN
  assign w_bypass  = w_empty & bus.fetch_valid & ~bus.resteer;
`else
  assign w_bypass  = 1'b0;
`endif

  assign w_valid = (~w_empty | w_bypass) & ~bus.resteer & ~rst;
  // Only a stored head advances rd_ptr; a bypassed entry never occupied a slot.
  assign w_pop   = w_valid & bus.d1_ready & ~w_empty;
  assign w_write = w_push_ok & ~(w_bypass & bus.d1_ready);

  assign bus.fetch_ready = ~w_full;
  assign bus.ibuff_valid = w_valid;
  assign bus.count       = r_count;

  always_comb begin
    bus.IBuff_out     = NOP;
    bus.pc_out        = '0;
    bus.exception_out = 1'b0;
    if (w_valid) begin
      if (w_empty) begin
        bus.IBuff_out     = bus.fetch_instr;
        bus.pc_out        = bus.fetch_pc;
        bus.exception_out = bus.fetch_exception;
      end else begin
        bus.IBuff_out     = r_instr_mem[r_rd_ptr];
        bus.pc_out        = r_pc_mem[r_rd_ptr];
        bus.exception_out = r_exc_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_instr_mem[r_wr_ptr] <= bus.fetch_instr;
      r_pc_mem[r_wr_ptr]    <= bus.fetch_pc;
      r_exc_mem[r_wr_ptr]   <= bus.fetch_exception;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.resteer) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_ibuff_queue.sv
// ============================================================================
// Module  : tb_ibuff_queue
// Brief   : Directed self-checking bench for ibuff_queue (DEPTH 8, XLEN 32).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ibuff_queue;
  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ibuff_queue_if #(.XLEN(32), .DEPTH(8)) bus ();

  ibuff_queue #(.XLEN(32), .DEPTH(8), .NOP(C_NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_valid     = 1'b0;
    bus.fetch_instr     = '0;
    bus.fetch_pc        = '0;
    bus.fetch_exception = 1'b0;
    bus.d1_ready        = 1'b0;
    bus.resteer         = 1'b0;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input logic exc);
    bus.fetch_valid     = 1'b1;
    bus.fetch_instr     = instr;
    bus.fetch_pc        = pc;
    bus.fetch_exception = exc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(bus.ibuff_valid), 32'd0);
    chk("rst_ready", 32'(bus.fetch_ready), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_instr", bus.IBuff_out, C_NOP);
    chk("rst_pc", bus.pc_out, 32'd0);
    chk("rst_exc", 32'(bus.exception_out), 32'd0);
    rst = 1'b0;

    // single push, visible one cycle later
    offer(32'hA5A5_A5A5, 32'h100, 1'b0);
    #1;
`ifdef IBUFF_BYPASS_EN
    chk("t1_same_cycle_valid", 32'(bus.ibuff_valid), 32'd1);
`else
    chk("t1_same_cycle_valid", 32'(bus.ibuff_valid), 32'd0);
`endif
    tick();
    idle();
    #1;
    chk("t1_valid", 32'(bus.ibuff_valid), 32'd1);
    chk("t1_instr", bus.IBuff_out, 32'hA5A5_A5A5);
    chk("t1_pc", bus.pc_out, 32'h100);
    chk("t1_count", 32'(bus.count), 32'd1);
    bus.d1_ready = 1'b1;
    tick();
    idle();
    #1;
    chk("t1_drained", 32'(bus.count), 32'd0);

    // fill to 8 (pointers start at 1 so the drain wraps)
    for (int i = 0; i < 8; i++) begin
      offer(32'h1000 + 32'(i), 32'h4 * 32'(i), 1'b0);
      tick();
    end
    idle();
    #1;
    chk("t2_full_count", 32'(bus.count), 32'd8);
    chk("t2_full_ready", 32'(bus.fetch_ready), 32'd0);
    offer(32'hDEAD_BEEF, 32'hFFC, 1'b0);
    tick();
    idle();
    #1;
    chk("t2_ninth_ignored", 32'(bus.count), 32'd8);
    bus.d1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_order_instr", bus.IBuff_out, 32'h1000 + 32'(i));
      chk("t2_order_pc", bus.pc_out, 32'h4 * 32'(i));
      tick();
    end
    idle();
    #1;
    chk("t2_empty_count", 32'(bus.count), 32'd0);
    chk("t2_empty_instr", bus.IBuff_out, C_NOP);
    chk("t2_empty_valid", 32'(bus.ibuff_valid), 32'd0);

    // full with simultaneous push+pop, then push+pop at count 3
    for (int i = 0; i < 8; i++) begin
      offer(32'h2000 + 32'(i), 32'h40 + 32'(i), 1'b0);
      tick();
    end
    offer(32'hBAD0_0001, 32'h0, 1'b0);
    bus.d1_ready = 1'b1;
    tick();
    idle();
    #1;
    chk("t3_full_pushpop_count", 32'(bus.count), 32'd7);
    chk("t3_full_pushpop_head", bus.IBuff_out, 32'h2001);
    bus.d1_ready = 1'b1;
    repeat (4) tick();
    idle();
    #1;
    chk("t3_count3", 32'(bus.count), 32'd3);
    chk("t3_head5", bus.IBuff_out, 32'h2005);
    offer(32'h3000, 32'h300, 1'b0);
    bus.d1_ready = 1'b1;
    tick();
    idle();
    #1;
    chk("t3_pushpop_count", 32'(bus.count), 32'd3);
    chk("t3_pushpop_head", bus.IBuff_out, 32'h2006);
    bus.d1_ready = 1'b1;
    tick();
    chk("t3_tail_a", bus.IBuff_out, 32'h2007);
    tick();
    chk("t3_tail_b", bus.IBuff_out, 32'h3000);
    tick();
    idle();
    #1;
    chk("t3_drained", 32'(bus.count), 32'd0);

    // resteer at count 5 drops everything including the offered entry
    for (int i = 0; i < 5; i++) begin
      offer(32'h4000 + 32'(i), 32'h400 + 32'(i), 1'b0);
      tick();
    end
    idle();
    #1;
    chk("t4_count5", 32'(bus.count), 32'd5);
    offer(32'hBAD0_0002, 32'h500, 1'b0);
    bus.resteer = 1'b1;
    #1;
    chk("t4_resteer_valid", 32'(bus.ibuff_valid), 32'd0);
    chk("t4_resteer_instr", bus.IBuff_out, C_NOP);
    tick();
    idle();
    #1;
    chk("t4_after_count", 32'(bus.count), 32'd0);
    chk("t4_after_valid", 32'(bus.ibuff_valid), 32'd0);
    offer(32'h4444, 32'h44, 1'b0);
    tick();
    idle();
    #1;
    chk("t4_repush_valid", 32'(bus.ibuff_valid), 32'd1);
    chk("t4_repush_instr", bus.IBuff_out, 32'h4444);
    chk("t4_repush_count", 32'(bus.count), 32'd1);
    bus.d1_ready = 1'b1;
    tick();
    idle();

    // exception flag travels with its entry
    offer(32'h5555, 32'h200, 1'b1);
    tick();
    offer(32'h6666, 32'h204, 1'b0);
    tick();
    idle();
    #1;
    chk("t5_exc_set", 32'(bus.exception_out), 32'd1);
    chk("t5_exc_pc", bus.pc_out, 32'h200);
    bus.d1_ready = 1'b1;
    tick();
    chk("t5_next_exc", 32'(bus.exception_out), 32'd0);
    chk("t5_next_pc", bus.pc_out, 32'h204);
    tick();
    idle();

    // asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) begin
      offer(32'h7000 + 32'(i), 32'h700 + 32'(i), 1'b0);
      tick();
    end
    idle();
    #1;
    chk("t6_count4", 32'(bus.count), 32'd4);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(bus.ibuff_valid), 32'd0);
    chk("t6_async_ready", 32'(bus.fetch_ready), 32'd1);
    chk("t6_async_count", 32'(bus.count), 32'd0);
    chk("t6_async_instr", bus.IBuff_out, C_NOP);
    tick();
    rst = 1'b0;

`ifdef IBUFF_BYPASS_EN
    offer(32'h8888, 32'h880, 1'b0);
    bus.d1_ready = 1'b1;
    #1;
    chk("byp_valid", 32'(bus.ibuff_valid), 32'd1);
    chk("byp_instr", bus.IBuff_out, 32'h8888);
    tick();
    idle();
    #1;
    chk("byp_count", 32'(bus.count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
